// File: rtl/cpu_pkg.sv
// Shared CPU type definitions: transfer sizes, writeback select and memory-stage states.
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'd0,
    MTR_MEM  = 2'd1,
    MTR_NORM = 2'd2
  } memtoreg_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// Zero-extends right-aligned load data to the full datapath width according to transfer size.
`default_nettype none

module load_extend
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        size_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    case (mem_size_t'(size_i))
      SZ_B:    data_o = {{(DATA_W-8){1'b0}},  rdata_i[7:0]};
      SZ_H:    data_o = {{(DATA_W-16){1'b0}}, rdata_i[15:0]};
      SZ_W:    data_o = {{(DATA_W-32){1'b0}}, rdata_i[31:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// Memory-access stage with req/ack data-memory handshake and the MEM/WB pipeline register.
`default_nettype none

module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_mem,
  input  logic [DATA_W-1:0] alu_result_mem,
  input  logic [DATA_W-1:0] norm_result_mem,
  input  logic [DATA_W-1:0] store_data_mem,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              RegWrite_mem,
  input  logic              MemRead_mem,
  input  logic              MemWrite_mem,
  input  logic [1:0]        MemToReg_mem,
  input  logic [1:0]        mem_size_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_size,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_mem,
  output logic              valid_wb,
  output logic              RegWrite_reg_wb,
  output logic [1:0]        MemToReg_wb,
  output logic [REG_AW-1:0] rd_wb,
  output logic [DATA_W-1:0] dmem_out_reg,
  output logic [DATA_W-1:0] alu_result_wb,
  output logic [DATA_W-1:0] norm_result_wb
);

  mem_state_t state_q, state_d;

  // Request registers: snapshot of the EX/MEM instruction for the whole transfer
  logic [DATA_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] norm_q,  norm_d;
  logic [1:0]        size_q,  size_d;
  logic              we_q,    we_d;
  logic [REG_AW-1:0] rd_q,    rd_d;
  logic              rw_q,    rw_d;
  logic [1:0]        mtr_q,   mtr_d;

  // MEM/WB register
  logic              wb_valid_q, wb_valid_d;
  logic              wb_rw_q,    wb_rw_d;
  logic [1:0]        wb_mtr_q,   wb_mtr_d;
  logic [REG_AW-1:0] wb_rd_q,    wb_rd_d;
  logic [DATA_W-1:0] wb_mem_q,   wb_mem_d;
  logic [DATA_W-1:0] wb_alu_q,   wb_alu_d;
  logic [DATA_W-1:0] wb_norm_q,  wb_norm_d;

  logic              mem_op;
  logic [DATA_W-1:0] ext_data;

  assign mem_op = valid_mem & (MemRead_mem | MemWrite_mem);

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .rdata_i (dmem_rdata),
    .size_i  (size_q),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    norm_d     = norm_q;
    size_d     = size_q;
    we_d       = we_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    mtr_d      = mtr_q;
    // Every path that does not retire an instruction loads an all-zero bubble
    wb_valid_d = 1'b0;
    wb_rw_d    = 1'b0;
    wb_mtr_d   = '0;
    wb_rd_d    = '0;
    wb_mem_d   = '0;
    wb_alu_d   = '0;
    wb_norm_d  = '0;
    stall_mem  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          addr_d    = alu_result_mem;
          wdata_d   = store_data_mem;
          norm_d    = norm_result_mem;
          size_d    = mem_size_mem;
          we_d      = MemWrite_mem;  // read+write together resolves to a store
          rd_d      = rd_mem;
          rw_d      = RegWrite_mem;
          mtr_d     = MemToReg_mem;
          stall_mem = 1'b1;
          state_d   = REQ;
        end else if (valid_mem) begin
          wb_valid_d = 1'b1;
          wb_rw_d    = RegWrite_mem;
          wb_mtr_d   = MemToReg_mem;
          wb_rd_d    = rd_mem;
          wb_alu_d   = alu_result_mem;
          wb_norm_d  = norm_result_mem;
        end
      end

      REQ: begin
        stall_mem = ~dmem_ack;
        if (dmem_ack) begin
          wb_valid_d = 1'b1;
          wb_rw_d    = rw_q;
          wb_mtr_d   = mtr_q;
          wb_rd_d    = rd_q;
          wb_mem_d   = we_q ? '0 : ext_data;
          wb_alu_d   = addr_q;
          wb_norm_d  = norm_q;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      norm_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      mtr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_mtr_q   <= '0;
      wb_rd_q    <= '0;
      wb_mem_q   <= '0;
      wb_alu_q   <= '0;
      wb_norm_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      norm_q     <= norm_d;
      size_q     <= size_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      mtr_q      <= mtr_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_mtr_q   <= wb_mtr_d;
      wb_rd_q    <= wb_rd_d;
      wb_mem_q   <= wb_mem_d;
      wb_alu_q   <= wb_alu_d;
      wb_norm_q  <= wb_norm_d;
    end
  end

  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_size  = size_q;

  assign valid_wb        = wb_valid_q;
  assign RegWrite_reg_wb = wb_rw_q;
  assign MemToReg_wb     = wb_mtr_q;
  assign rd_wb           = wb_rd_q;
  assign dmem_out_reg    = wb_mem_q;
  assign alu_result_wb   = wb_alu_q;
  assign norm_result_wb  = wb_norm_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, corner sequences, randomized ops.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_mem;
  logic [63:0] alu_result_mem, norm_result_mem, store_data_mem;
  logic [4:0]  rd_mem;
  logic        RegWrite_mem, MemRead_mem, MemWrite_mem;
  logic [1:0]  MemToReg_mem, mem_size_mem;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [1:0]  dmem_size;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        stall_mem, valid_wb, RegWrite_reg_wb;
  logic [1:0]  MemToReg_wb;
  logic [4:0]  rd_wb;
  logic [63:0] dmem_out_reg, alu_result_wb, norm_result_wb;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(64), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .valid_mem(valid_mem),
    .alu_result_mem(alu_result_mem), .norm_result_mem(norm_result_mem),
    .store_data_mem(store_data_mem), .rd_mem(rd_mem), .RegWrite_mem(RegWrite_mem),
    .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem), .MemToReg_mem(MemToReg_mem),
    .mem_size_mem(mem_size_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_size(dmem_size),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .valid_wb(valid_wb), .RegWrite_reg_wb(RegWrite_reg_wb), .MemToReg_wb(MemToReg_wb),
    .rd_wb(rd_wb), .dmem_out_reg(dmem_out_reg), .alu_result_wb(alu_result_wb),
    .norm_result_wb(norm_result_wb)
  );

  typedef struct {
    logic        valid, rw, mr, mw;
    logic [1:0]  mtr, size;
    logic [63:0] alu, norm, sd;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          waits;
    logic [63:0] exp_out;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a load returns the low 2^size bytes of rdata, zero-extended
  function automatic logic [63:0] model_ext(input logic [63:0] rdata, input logic [1:0] sz);
    int          nbits;
    logic [63:0] mask;
    nbits = 8 * (1 << sz);
    if (nbits >= 64) mask = '1;
    else mask = (64'd1 << nbits) - 64'd1;
    return rdata & mask;
  endfunction

  task automatic drive_idle();
    valid_mem = 0; alu_result_mem = '0; norm_result_mem = '0; store_data_mem = '0;
    rd_mem = '0; RegWrite_mem = 0; MemRead_mem = 0; MemWrite_mem = 0;
    MemToReg_mem = '0; mem_size_mem = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic check_wb(input vec_t v, input logic exp_valid, input logic [63:0] exp_out);
    chk("valid_wb", valid_wb, exp_valid);
    chk("RegWrite_wb", RegWrite_reg_wb, exp_valid & v.rw);
    chk("dmem_out_reg", dmem_out_reg, exp_out);
    if (exp_valid) begin
      chk("rd_wb", rd_wb, v.rd);
      chk("MemToReg_wb", MemToReg_wb, v.mtr);
      chk("alu_result_wb", alu_result_wb, v.alu);
      chk("norm_result_wb", norm_result_wb, v.norm);
    end
  endtask

  // Presents one instruction in the current cycle and plays the memory side.
  // Called just after a rising edge; returns just after the edge that retires it.
  task automatic apply(input vec_t v);
    bit memop;
    int stalls;
    memop = v.valid && (v.mr || v.mw);
    stalls = 0;
    valid_mem = v.valid; RegWrite_mem = v.rw; MemRead_mem = v.mr; MemWrite_mem = v.mw;
    MemToReg_mem = v.mtr; mem_size_mem = v.size; alu_result_mem = v.alu;
    norm_result_mem = v.norm; store_data_mem = v.sd; rd_mem = v.rd;
    dmem_ack = 0; dmem_rdata = v.rdata;
    #1;
    if (!memop) begin
      chk("stall_nonmem", stall_mem, 1'b0);
      @(posedge clk); #1;
      check_wb(v, v.valid, 64'd0);
    end else begin
      chk("stall_idle", stall_mem, 1'b1);
      chk("req_idle", dmem_req, 1'b0);
      if (stall_mem) stalls++;
      @(posedge clk); #1;
      // Request must come from the latched copy, not the live EX/MEM data
      alu_result_mem = ~v.alu; norm_result_mem = ~v.norm;
      store_data_mem = ~v.sd; rd_mem = ~v.rd;
      for (int k = 0; k <= v.waits; k++) begin
        dmem_ack = (k == v.waits);
        #1;
        chk("dmem_req", dmem_req, 1'b1);
        chk("dmem_addr", dmem_addr, v.alu);
        chk("dmem_wdata", dmem_wdata, v.sd);
        chk("dmem_size", dmem_size, v.size);
        chk("dmem_we", dmem_we, v.mw);
        chk("valid_wb_wait", valid_wb, 1'b0);
        chk("RegWrite_wb_wait", RegWrite_reg_wb, 1'b0);
        chk("stall_req", stall_mem, (k != v.waits));
        if (stall_mem) stalls++;
        @(posedge clk); #1;
      end
      dmem_ack = 0;
      chk("stall_cycles", stalls, v.waits + 1);
      chk("req_after_ack", dmem_req, 1'b0);
      check_wb(v, 1'b1, v.exp_out);
    end
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 64'h10,  64'h55,   64'h0,    5'd3,
               64'h0, 0, 64'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 64'h100, 64'h0,    64'h0,    5'd5,
               64'hFFEEDDCCBBAA9988, 0, 64'h88};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 64'h200, 64'h0,    64'h1234, 5'd0,
               64'h0, 2, 64'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 64'h300, 64'h0,    64'h0,    5'd7,
               64'hAAAAAAAA_CAFEBABE, 0, 64'hCAFEBABE};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 64'h308, 64'h0,    64'h0,    5'd8,
               64'hAAAAAAAA_CAFEBABE, 0, 64'hCAFEBABE};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 64'h40,  64'h0,    64'h0,    5'd9,
               64'h1122334455667788, 1, 64'h7788};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 64'h80,  64'h0,    64'h0,    5'd4,
               64'hFF, 0, 64'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 64'h50,  64'h0,    64'hABCD, 5'd2,
               64'hFFFF, 0, 64'h0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 64'h1,   64'hDEAD, 64'h0,    5'd31,
               64'h0, 0, 64'h0};

    drive_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_we", dmem_we, 1'b0);
    chk("rst_dmem_addr", dmem_addr, 64'd0);
    chk("rst_dmem_wdata", dmem_wdata, 64'd0);
    chk("rst_dmem_size", dmem_size, 2'd0);
    chk("rst_stall", stall_mem, 1'b0);
    chk("rst_valid_wb", valid_wb, 1'b0);
    chk("rst_dmem_out", dmem_out_reg, 64'd0);
    chk("rst_alu_wb", alu_result_wb, 64'd0);
    reset = 0;

    for (int i = 0; i < 9; i++) apply(tbl[i]);

    // Reset while a transfer is outstanding abandons it; a late ack is ignored
    apply(tbl[8]);
    valid_mem = 1; MemRead_mem = 1; MemWrite_mem = 0; RegWrite_mem = 1;
    alu_result_mem = 64'h400; mem_size_mem = 2'd3; dmem_ack = 0;
    @(posedge clk); #1;
    chk("midreq_req", dmem_req, 1'b1);
    reset = 1;
    drive_idle();
    @(posedge clk); #1;
    chk("rstreq_dmem_req", dmem_req, 1'b0);
    chk("rstreq_valid_wb", valid_wb, 1'b0);
    chk("rstreq_rw_wb", RegWrite_reg_wb, 1'b0);
    chk("rstreq_rd_wb", rd_wb, 5'd0);
    chk("rstreq_alu_wb", alu_result_wb, 64'd0);
    chk("rstreq_norm_wb", norm_result_wb, 64'd0);
    chk("rstreq_out", dmem_out_reg, 64'd0);
    chk("rstreq_stall", stall_mem, 1'b0);
    reset = 0;
    dmem_ack = 1; dmem_rdata = '1;
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("lateack_req", dmem_req, 1'b0);
    chk("lateack_valid", valid_wb, 1'b0);
    chk("lateack_out", dmem_out_reg, 64'd0);

    // Ack in IDLE alongside a non-memory op
    valid_mem = 1; RegWrite_mem = 1; MemToReg_mem = 2'd0; alu_result_mem = 64'h77;
    rd_mem = 5'd6; dmem_ack = 1; dmem_rdata = '1;
    @(posedge clk); #1;
    chk("idleack_valid", valid_wb, 1'b1);
    chk("idleack_out", dmem_out_reg, 64'd0);
    chk("idleack_alu", alu_result_wb, 64'h77);
    chk("idleack_req", dmem_req, 1'b0);
    drive_idle();
    @(posedge clk); #1;
    chk("idleack_req2", dmem_req, 1'b0);

    // Randomized instruction stream against the reference model
    for (int i = 0; i < 60; i++) begin
      v.valid = ($urandom_range(0, 7) != 0);
      v.rw    = $urandom_range(0, 1);
      v.mr    = $urandom_range(0, 1);
      v.mw    = ($urandom_range(0, 3) == 0);
      v.mtr   = 2'($urandom_range(0, 2));
      v.size  = 2'($urandom_range(0, 3));
      v.alu   = {$urandom, $urandom};
      v.norm  = {$urandom, $urandom};
      v.sd    = {$urandom, $urandom};
      v.rd    = 5'($urandom_range(0, 31));
      v.rdata = {$urandom, $urandom};
      v.waits = $urandom_range(0, 3);
      v.exp_out = (v.valid && v.mr && !v.mw) ? model_ext(v.rdata, v.size) : 64'd0;
      apply(v);
    end
    drive_idle();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage plus MEM/WB pipeline register of the 64-bit pipelined ARM CPU. Takes EX/MEM results, runs loads/stores against a data memory with a req/ack handshake (stalling upstream while a transfer is outstanding), size-extends load data, and registers everything the writeback stage consumes: register-write enable, mem-to-reg select, memory data, ALU result and normalizer result.

## Interface
Parameters:
- DATA_W, 64, datapath width.
- REG_AW, 5, register-index width.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  stage clock.
- reset  in  1  synchronous, active-high reset.
- valid_mem  in  1  EX/MEM holds a real instruction.
- alu_result_mem  in  64  ALU result; also memory address.
- norm_result_mem  in  64  normalizer result.
- store_data_mem  in  64  store data (low bytes used per size).
- rd_mem  in  5  destination register.
- RegWrite_mem  in  1  writes a register.
- MemRead_mem  in  1  load.
- MemWrite_mem  in  1  store.
- MemToReg_mem  in  2  writeback select (0 ALU, 1 mem, 2 norm).
- mem_size_mem  in  2  0 byte, 1 half, 2 word, 3 dword.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  64  byte address.
- dmem_wdata  out  64  store data.
- dmem_size  out  2  transfer size.
- dmem_ack  in  1  memory done; rdata valid same cycle.
- dmem_rdata  in  64  load data, right-aligned.
- stall_mem  out  1  upstream must hold EX/MEM contents.
- valid_wb  out  1  WB register holds a real instruction.
- RegWrite_reg_wb  out  1  to WB.
- MemToReg_wb  out  2  to WB.
- rd_wb  out  5  to WB.
- dmem_out_reg  out  64  extended load data.
- alu_result_wb  out  64  to WB.
- norm_result_wb  out  64  to WB.

## Operation
- mem_op = valid_mem & (MemRead_mem | MemWrite_mem).
- FSM states IDLE, REQ. Reset -> IDLE.
- IDLE, no mem_op: WB register loads EX/MEM fields directly (1-cycle pass-through); dmem_out_reg loads 0; stall_mem=0.
- IDLE, mem_op: latch address, wdata, size, we, rd, RegWrite, MemToReg, alu/norm results into request registers; stall_mem=1; WB register loads bubble (valid_wb=0, RegWrite_reg_wb=0); go REQ.
- REQ: dmem_req=1 with latched request fields, held stable until ack. stall_mem = ~dmem_ack. On dmem_ack: WB register loads latched fields, valid_wb=1, dmem_out_reg = extended rdata (stores: 0); go IDLE. Without ack: WB bubble, stay.
- Load extension: zero-extend rdata[7:0], [15:0], [31:0] or full 64 per size.
- Store: dmem_wdata = store_data unmodified; memory uses dmem_size for byte enables. RegWrite on stores is passed through as latched (normally 0).
- dmem_ack in IDLE ignored. Both MemRead and MemWrite set: treated as store.
- valid_mem=0: WB bubble regardless of control bits.

## Timing
- Reset values: state IDLE, dmem_req=0, dmem_we=0, dmem_addr/wdata/size=0, all WB outputs 0, stall_mem=0 (comb, 0 in IDLE with valid_mem=0).
- Non-memory instruction: visible on WB outputs 1 cycle after presentation.
- Memory op, ack on first REQ cycle: WB outputs valid 2 cycles after presentation; stall_mem high exactly 1 cycle. Each extra wait cycle adds 1 cycle of stall and latency.
- stall_mem drops in the ack cycle; upstream advances at that edge; next instruction sampled in IDLE the following cycle (no retrigger of same op).
- Back-to-back memory ops: one IDLE cycle between requests (dmem_req low for exactly 1 cycle).
- Reset mid-REQ: next edge IDLE, dmem_req=0, WB cleared; transfer abandoned.

## Structure
- Shared cpu_pkg: mem_size_t (SZ_B/SZ_H/SZ_W/SZ_D), memtoreg_t (MTR_ALU=0, MTR_MEM=1, MTR_NORM=2), mem_state_t (IDLE, REQ).
- One sub-module: load_extend (combinational, rdata + size -> 64-bit zero-extended value).

## Test plan
- Reset then ADD pass-through, alu_result_mem=0x10, rd=3, RegWrite=1 -> next cycle valid_wb=1, alu_result_wb=0x10, rd_wb=3, stall_mem never high.
- LDURB addr 0x100, rdata=0xFFEEDDCCBBAA9988, ack on first REQ cycle -> stall 1 cycle, dmem_out_reg=0x88, MemToReg_wb=1, 2-cycle latency.
- STUR dword addr 0x200, wdata 0x1234, ack after 3 REQ cycles -> dmem_req high 3 cycles with stable addr/wdata/we=1, stall_mem 3 cycles, WB bubbles during wait, RegWrite_reg_wb=0.
- Two LDURW back-to-back, rdata 0xAAAAAAAA_CAFEBABE -> dmem_out_reg=0xCAFEBABE each, dmem_req low exactly 1 cycle between.
- Reset asserted while in REQ without ack -> dmem_req=0 and all WB outputs 0 next cycle; late ack ignored.
- ack pulsed in IDLE with non-mem op -> no state change, dmem_out_reg=0.
